// File: rtl/ysyx22041405_mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// iteration step mode and the most-negative-value helper.
package ysyx22041405_mdu_pkg;

   // RV M-extension funct3 encodings
   typedef enum logic [2:0] {
      MDU_MUL    = 3'b000,
      MDU_MULH   = 3'b001,
      MDU_MULHSU = 3'b010,
      MDU_MULHU  = 3'b011,
      MDU_DIV    = 3'b100,
      MDU_DIVU   = 3'b101,
      MDU_REM    = 3'b110,
      MDU_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   typedef enum logic {
      ITER_MUL = 1'b0,
      ITER_DIV = 1'b1
   } iter_mode_e;

   localparam int MAX_WIDTH = 128;

   // Most negative two's-complement value of the given width, zero-extended
   function automatic logic [MAX_WIDTH-1:0] INT_MIN(input int width);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      v[width-1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/ysyx22041405_mdu_iter.sv
// One iteration of the shift-add multiplier or the restoring divider.
// Accumulator layout is {hi, lo}:
//   multiply: hi = partial product, lo = remaining multiplier bits (LSB first)
//   divide:   hi = partial remainder, lo = dividend bits shifting into quotient
module ysyx22041405_mdu_iter
   import ysyx22041405_mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   operand_i,
   input  iter_mode_e         mode_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   part;
   logic [WIDTH:0]   diff;

   // Single shift-add or trial-subtract step; diff[WIDTH] acts as the borrow
   always_comb begin
      hi   = acc_i[2*WIDTH-1:WIDTH];
      lo   = acc_i[WIDTH-1:0];
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, operand_i} : '0);
      part = {hi, lo[WIDTH-1]};
      diff = part - {1'b0, operand_i};
      if (mode_i == ITER_MUL) begin
         acc_o = {sum, lo[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
         acc_o = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
      end else begin
         acc_o = {part[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/ysyx22041405_mdu.sv
// Iterative multiply/divide unit with valid/ready request and response.
// Operands are converted to magnitudes on accept; sign correction is applied
// once when the final result is written.
module ysyx22041405_mdu
   import ysyx22041405_mdu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   localparam logic [WIDTH-1:0] INT_MIN_W = WIDTH'(INT_MIN(WIDTH));
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   mdu_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   mdu_op_e            op_q, op_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   result_q, result_d;

   mdu_op_e            op_in;
   logic               fire;
   logic               sgn1, sgn2, neg1, neg2;
   logic [WIDTH-1:0]   abs1, abs2;
   logic               div_zero, div_ovf;
   logic [WIDTH-1:0]   special_res;

   iter_mode_e         iter_mode;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_mag, rem_mag;
   logic [WIDTH-1:0]   calc_res;

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign fire      = in_valid & in_ready & ~flush;
   assign iter_mode = op_q[2] ? ITER_DIV : ITER_MUL;

   ysyx22041405_mdu_iter #(.WIDTH(WIDTH)) u_iter (
      .acc_i     (acc_q),
      .operand_i (opnd_q),
      .mode_i    (iter_mode),
      .acc_o     (acc_nxt)
   );

   // Request decode: operand signedness, magnitudes and early-out cases
   always_comb begin
      op_in       = mdu_op_e'(in_op);
      sgn1        = (op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
                    (op_in == MDU_DIV)  || (op_in == MDU_REM);
      sgn2        = (op_in == MDU_MULH) || (op_in == MDU_DIV) || (op_in == MDU_REM);
      neg1        = sgn1 & src1[WIDTH-1];
      neg2        = sgn2 & src2[WIDTH-1];
      abs1        = neg1 ? -src1 : src1;
      abs2        = neg2 ? -src2 : src2;
      div_zero    = in_op[2] && (src2 == '0);
      div_ovf     = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                    (src1 == INT_MIN_W) && (src2 == '1);
      special_res = '0;
      if (div_zero) begin
         special_res = ((op_in == MDU_DIV) || (op_in == MDU_DIVU)) ? '1 : src1;
      end else if (div_ovf) begin
         special_res = (op_in == MDU_DIV) ? src1 : '0;
      end
   end

   // Final result from the last iteration's accumulator with sign correction
   always_comb begin
      prod_s   = neg_res_q ? -acc_nxt : acc_nxt;
      quo_mag  = acc_nxt[WIDTH-1:0];
      rem_mag  = acc_nxt[2*WIDTH-1:WIDTH];
      calc_res = '0;
      unique case (op_q)
         MDU_MUL:                        calc_res = prod_s[WIDTH-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: calc_res = prod_s[2*WIDTH-1:WIDTH];
         MDU_DIV, MDU_DIVU:              calc_res = neg_res_q ? -quo_mag : quo_mag;
         MDU_REM, MDU_REMU:              calc_res = neg_rem_q ? -rem_mag : rem_mag;
         default:                        calc_res = '0;
      endcase
   end

   // FSM next state and datapath updates; flush overrides every transition
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      op_d      = op_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      unique case (state_q)
         ST_IDLE: begin
            if (fire) begin
               op_d      = op_in;
               neg_res_d = neg1 ^ neg2;
               neg_rem_d = neg1;
               acc_d     = {{WIDTH{1'b0}}, abs1};
               opnd_d    = abs2;
               cnt_d     = '0;
               if (div_zero || div_ovf) begin
                  result_d = special_res;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               result_d = calc_res;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d = ST_IDLE;
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         op_q      <= MDU_MUL;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         op_q      <= op_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

endmodule

// File: tb/tb_ysyx22041405_mdu.sv
// Scoreboard bench for ysyx22041405_mdu: stimulus pushes expected results,
// an independent monitor pops and checks them on each result handshake.
module tb_ysyx22041405_mdu;

   localparam int W = 32;
   localparam logic [W-1:0] IMIN = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   in_op = 3'd0;
   logic [W-1:0] src1 = '0;
   logic [W-1:0] src2 = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;

   ysyx22041405_mdu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .src1      (src1),
      .src2      (src2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] exp;
      int           lat;
      int           fire;
   } txn_t;

   txn_t         sb[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   bit           rand_rdy = 1'b0;
   bit           forced_rdy = 1'b1;
   bit           mon_seen = 1'b0;
   logic [W-1:0] mon_hold = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model straight from the M-extension definitions using 64-bit math
   function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      longint          sa, sbv, ub, p;
      longint unsigned ua, ubu, pu;
      logic [W-1:0]    r;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ub  = longint'({32'h0, b});
      ua  = {32'h0, a};
      ubu = {32'h0, b};
      r   = '0;
      case (op)
         3'd0: begin p = sa * sbv; r = p[31:0]; end
         3'd1: begin p = sa * sbv; r = p[63:32]; end
         3'd2: begin p = sa * ub;  r = p[63:32]; end
         3'd3: begin pu = ua * ubu; r = pu[63:32]; end
         3'd4: begin
            if (b == 0) r = '1;
            else if (a == IMIN && b == '1) r = a;
            else begin p = sa / sbv; r = p[31:0]; end
         end
         3'd5: r = (b == 0) ? '1 : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == IMIN && b == '1) r = '0;
            else begin p = sa % sbv; r = p[31:0]; end
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
      bit special;
      special = op[2] && ((b == 0) || ((op == 3'd4 || op == 3'd6) && a == IMIN && b == '1));
      return special ? 1 : W + 1;
   endfunction

   // Result handshake driver: random backpressure or a forced level
   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : forced_rdy;
      end
   end

   // Monitor: latency on first valid, stability while held, value on handshake
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", {31'b0, out_valid}, '0);
         end else begin
            if (!mon_seen) begin
               mon_seen = 1'b1;
               mon_hold = result;
               check("latency", W'(cyc - sb[0].fire), W'(sb[0].lat));
            end else begin
               check("result_stable", result, mon_hold);
            end
            check("in_ready_in_done", {31'b0, in_ready}, '0);
            if (out_ready) begin
               check("result", result, sb[0].exp);
               void'(sb.pop_front());
               mon_seen = 1'b0;
            end
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int   n;
      txn_t t;
      n = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_op    = op;
      src1     = a;
      src2     = b;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("issue_timeout", {31'b0, in_ready}, 32'd1);
         in_valid = 1'b0;
         return;
      end
      t.exp  = model(op, a, b);
      t.lat  = model_lat(op, a, b);
      t.fire = cyc;
      sb.push_back(t);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", W'(sb.size()), '0);
      sb.delete();
      mon_seen = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wait_out_valid", {31'b0, out_valid}, 32'd1);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'd1;
         2:       return '1;
         3:       return IMIN;
         4:       return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      logic [W-1:0] bp_exp;
      int           fire_c;
      int           n;

      // reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, '0);
      check("rst_result", result, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // directed arithmetic and special cases
      forced_rdy = 1'b1;
      issue(3'd0, 32'd7, 32'hFFFF_FFFD);
      issue(3'd1, IMIN, IMIN);
      issue(3'd3, '1, '1);
      issue(3'd2, '1, 32'd2);
      issue(3'd4, 32'hFFFF_FFF9, 32'd2);
      issue(3'd6, 32'hFFFF_FFF9, 32'd2);
      issue(3'd5, 32'd100, 32'd7);
      issue(3'd7, 32'd100, 32'd7);
      issue(3'd4, 32'd5, '0);
      issue(3'd7, 32'd5, '0);
      issue(3'd4, IMIN, '1);
      issue(3'd6, IMIN, '1);
      issue(3'd5, 32'd9, '0);
      issue(3'd6, 32'd9, '0);
      drain();

      // backpressure: result held, no acceptance while DONE
      forced_rdy = 1'b0;
      bp_exp = model(3'd0, 32'h1234_5678, 32'd9);
      issue(3'd0, 32'h1234_5678, 32'd9);
      wait_valid();
      repeat (10) begin
         @(negedge clk);
         check("bp_result", result, bp_exp);
         check("bp_in_ready", {31'b0, in_ready}, '0);
         check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      end
      forced_rdy = 1'b1;
      n = 0;
      while (out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
      check("bp_release_out_valid", {31'b0, out_valid}, '0);
      drain();

      // flush at CALC cycle 10
      issue(3'd5, 32'hDEAD_BEEF, 32'h0000_1234);
      fire_c = sb[$].fire;
      n = 0;
      while (cyc != fire_c + 10 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      flush = 1'b1;
      void'(sb.pop_back());
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_in_ready", {31'b0, in_ready}, 32'd1);
      check("flush_out_valid", {31'b0, out_valid}, '0);

      // request together with flush must not be accepted
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_op    = 3'd0;
      src1     = 32'd5;
      src2     = 32'd6;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      @(negedge clk);
      check("flush_blocks_fire", {31'b0, in_ready}, 32'd1);
      issue(3'd0, 32'd3, 32'd4);
      drain();

      // reset while in DONE
      forced_rdy = 1'b0;
      issue(3'd5, 32'd100, 32'd7);
      wait_valid();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      mon_seen = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_done_out_valid", {31'b0, out_valid}, '0);
      check("rst_done_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_done_result", result, '0);
      #1;
      rst_n = 1'b1;
      forced_rdy = 1'b1;

      // randomized ops with random response backpressure
      rand_rdy = 1'b1;
      repeat (80) begin
         issue(3'($urandom_range(0, 7)), pick(), pick());
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      drain();
      rand_rdy = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
